// File: rtl/axi_llc_r_refill_master_if.sv
// -----------------------------------------------------------------------------
// axi_llc_r_refill_master_if
//
// Bundles the bus-side signals of the LLC refill R-channel master:
//   - descriptor input  (desc_*_i / desc_ready_o) from the in-flight AR FIFO
//   - descriptor output (desc_*_o / desc_ready_i) to the downstream stage
//   - AXI R channel     (r_*_i / r_ready_o)
//   - data-way write    (way_inp_*_o / way_inp_ready_i)
//
// Modports:
//   master : view of the refill master itself
//   slave  : view of the surrounding environment (FIFO, R source, way, sink)
// -----------------------------------------------------------------------------
interface axi_llc_r_refill_master_if #(
    parameter int unsigned SetAssociativity  = 8,
    parameter int unsigned IndexLength       = 8,
    parameter int unsigned BlockOffsetLength = 3,
    parameter int unsigned DataWidth         = 64,
    parameter int unsigned IdWidth           = 4
) ();

    // Descriptor input
    logic                         desc_valid_i;
    logic                         desc_ready_o;
    logic                         desc_refill_i;
    logic [SetAssociativity-1:0]  desc_way_ind_i;
    logic [IndexLength-1:0]       desc_index_i;
    logic [IdWidth-1:0]           desc_id_i;

    // Descriptor output
    logic                         desc_valid_o;
    logic                         desc_ready_i;
    logic [SetAssociativity-1:0]  desc_way_ind_o;
    logic [IndexLength-1:0]       desc_index_o;
    logic [IdWidth-1:0]           desc_id_o;
    logic                         desc_err_o;

    // AXI R channel
    logic [DataWidth-1:0]         r_data_i;
    logic [1:0]                   r_resp_i;
    logic                         r_last_i;
    logic                         r_valid_i;
    logic                         r_ready_o;

    // Data-way write port
    logic                         way_inp_valid_o;
    logic                         way_inp_ready_i;
    logic [SetAssociativity-1:0]  way_inp_way_ind_o;
    logic [IndexLength-1:0]       way_inp_index_o;
    logic [BlockOffsetLength-1:0] way_inp_blk_offset_o;
    logic [DataWidth-1:0]         way_inp_data_o;

    modport master (
        input  desc_valid_i, desc_refill_i, desc_way_ind_i, desc_index_i, desc_id_i,
        output desc_ready_o,
        output desc_valid_o, desc_way_ind_o, desc_index_o, desc_id_o, desc_err_o,
        input  desc_ready_i,
        input  r_data_i, r_resp_i, r_last_i, r_valid_i,
        output r_ready_o,
        output way_inp_valid_o, way_inp_way_ind_o, way_inp_index_o,
        output way_inp_blk_offset_o, way_inp_data_o,
        input  way_inp_ready_i
    );

    modport slave (
        output desc_valid_i, desc_refill_i, desc_way_ind_i, desc_index_i, desc_id_i,
        input  desc_ready_o,
        input  desc_valid_o, desc_way_ind_o, desc_index_o, desc_id_o, desc_err_o,
        output desc_ready_i,
        output r_data_i, r_resp_i, r_last_i, r_valid_i,
        input  r_ready_o,
        input  way_inp_valid_o, way_inp_way_ind_o, way_inp_index_o,
        input  way_inp_blk_offset_o, way_inp_data_o,
        output way_inp_ready_i
    );

endinterface

// File: rtl/axi_llc_r_refill_master.sv
// -----------------------------------------------------------------------------
// axi_llc_r_refill_master
//
// R-channel master of the LLC refill pipeline. Accepts a descriptor whose AR
// has already been issued, streams the 2**BlockOffsetLength R beats of the
// line straight into the selected data way at consecutive block offsets,
// accumulates response/RLAST errors and then presents the descriptor
// downstream. Descriptors that need no refill bypass the R channel.
//
// Ports:
//   clk_i   : clock, rising edge
//   rst_ni  : asynchronous reset, active low
//   bus     : axi_llc_r_refill_master_if.master (descriptor in/out, R channel,
//             data-way write port)
// -----------------------------------------------------------------------------
module axi_llc_r_refill_master #(
    parameter int unsigned SetAssociativity  = 8,
    parameter int unsigned IndexLength       = 8,
    parameter int unsigned BlockOffsetLength = 3,
    parameter int unsigned DataWidth         = 64,
    parameter int unsigned IdWidth           = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    axi_llc_r_refill_master_if.master bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REFILL = 2'd1,
        SEND   = 2'd2
    } state_e;

    localparam logic [BlockOffsetLength-1:0] LastBeat = '1;

    state_e                       state_q, state_d;
    logic [SetAssociativity-1:0]  way_ind_q, way_ind_d;
    logic [IndexLength-1:0]       index_q, index_d;
    logic [IdWidth-1:0]           id_q, id_d;
    logic [BlockOffsetLength-1:0] cnt_q, cnt_d;
    logic                         err_q, err_d;

    logic desc_accept;
    logic beat_fire;
    logic last_beat;

    // One handshake serves both the R channel and the way write port, so a
    // beat moves exactly when the source has data and the way can take it.
    assign desc_accept = (state_q == IDLE) && bus.desc_valid_i;
    assign beat_fire   = (state_q == REFILL) && bus.r_valid_i && bus.way_inp_ready_i;
    assign last_beat   = (cnt_q == LastBeat);

    // -------------------------------------------------------------------------
    // State and datapath registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its pre-edge value, independent of process evaluation order.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            way_ind_q <= '0;
            index_q   <= '0;
            id_q      <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            way_ind_q <= way_ind_d;
            index_q   <= index_d;
            id_q      <= id_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    // NOTE: every always_comb output gets a default before any branch, so no
    // path can leave it unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (bus.desc_valid_i) begin
                    state_d = bus.desc_refill_i ? REFILL : SEND;
                end
            end
            REFILL: begin
                // Beat count alone ends the refill; an early RLAST is only
                // flagged as an error.
                if (beat_fire && last_beat) begin
                    state_d = SEND;
                end
            end
            SEND: begin
                if (bus.desc_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Descriptor capture, beat counter and error accumulation
    // -------------------------------------------------------------------------
    always_comb begin
        way_ind_d = way_ind_q;
        index_d   = index_q;
        id_d      = id_q;
        cnt_d     = cnt_q;
        err_d     = err_q;

        if (desc_accept) begin
            way_ind_d = bus.desc_way_ind_i;
            index_d   = bus.desc_index_i;
            id_d      = bus.desc_id_i;
            cnt_d     = '0;
            err_d     = 1'b0;
        end else if (beat_fire) begin
            // Counter wraps back to 0 on the final beat, ready for the next line.
            cnt_d = cnt_q + BlockOffsetLength'(1);
            // resp[1] covers SLVERR and DECERR; RLAST must coincide with the
            // final beat and nowhere else.
            err_d = err_q | bus.r_resp_i[1] | (bus.r_last_i != last_beat);
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    always_comb begin
        // IDLE is also the reset state, so ready is qualified by reset to keep
        // it low while the block is held in reset.
        bus.desc_ready_o = rst_ni && (state_q == IDLE);

        bus.desc_valid_o   = (state_q == SEND);
        bus.desc_err_o     = (state_q == SEND) && err_q;
        bus.desc_way_ind_o = way_ind_q;
        bus.desc_index_o   = index_q;
        bus.desc_id_o      = id_q;

        // Zero-latency pass-through; valid never looks at ready.
        bus.way_inp_valid_o = (state_q == REFILL) && bus.r_valid_i;
        bus.r_ready_o       = (state_q == REFILL) && bus.way_inp_ready_i;

        bus.way_inp_way_ind_o    = way_ind_q;
        bus.way_inp_index_o      = index_q;
        bus.way_inp_blk_offset_o = cnt_q;
        // Data is forwarded only while refilling so the port reads 0 otherwise.
        bus.way_inp_data_o       = (state_q == REFILL) ? bus.r_data_i : '0;
    end

endmodule

// File: tb/tb_axi_llc_r_refill_master.sv
// -----------------------------------------------------------------------------
// tb_axi_llc_r_refill_master
//
// Directed bench for axi_llc_r_refill_master. Inputs change 1 time unit after
// the rising edge; outputs are sampled on the falling edge. A falling-edge
// monitor logs every way write (valid && ready) for the scenario tasks.
// -----------------------------------------------------------------------------
module tb_axi_llc_r_refill_master;

    localparam int unsigned SA  = 8;
    localparam int unsigned IL  = 8;
    localparam int unsigned BOL = 3;
    localparam int unsigned DW  = 64;
    localparam int unsigned IW  = 4;

    logic clk_i;
    logic rst_ni;

    axi_llc_r_refill_master_if #(
        .SetAssociativity (SA),
        .IndexLength      (IL),
        .BlockOffsetLength(BOL),
        .DataWidth        (DW),
        .IdWidth          (IW)
    ) bus ();

    axi_llc_r_refill_master #(
        .SetAssociativity (SA),
        .IndexLength      (IL),
        .BlockOffsetLength(BOL),
        .DataWidth        (DW),
        .IdWidth          (IW)
    ) dut (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .bus   (bus)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    // Way-write log filled by the monitor only.
    logic [BOL-1:0] wr_off  [256];
    logic [DW-1:0]  wr_data [256];
    logic [SA-1:0]  wr_way  [256];
    logic [IL-1:0]  wr_idx  [256];
    int             wr_n      = 0;
    int             rr_pulses = 0;

    always @(negedge clk_i) begin
        if (bus.way_inp_valid_o && bus.way_inp_ready_i && wr_n < 256) begin
            wr_off[wr_n]  = bus.way_inp_blk_offset_o;
            wr_data[wr_n] = bus.way_inp_data_o;
            wr_way[wr_n]  = bus.way_inp_way_ind_o;
            wr_idx[wr_n]  = bus.way_inp_index_o;
            wr_n++;
        end
        if (bus.r_ready_o === 1'b1) rr_pulses++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------------------------------------------------------- stimulus
    task automatic send_desc(input logic refill, input logic [SA-1:0] way,
                             input logic [IL-1:0] idx, input logic [IW-1:0] id);
        bus.desc_valid_i   = 1'b1;
        bus.desc_refill_i  = refill;
        bus.desc_way_ind_i = way;
        bus.desc_index_i   = idx;
        bus.desc_id_i      = id;
        @(posedge clk_i); #1;
        bus.desc_valid_i   = 1'b0;
        bus.desc_refill_i  = 1'b0;
    endtask

    // Drives one line of R beats. Returns beats taken, loop cycles used and the
    // number of cycles where r_ready_o differed from the driven way ready.
    task automatic drive_beats(input logic [DW-1:0] base, input int bad_beat,
                               input int last_at, input bit toggle,
                               output int beats, output int cyc, output int mirror_bad);
        beats = 0; cyc = 0; mirror_bad = 0;
        while (beats < 8 && cyc < 64) begin
            bus.r_valid_i       = 1'b1;
            bus.r_data_i        = base + DW'(beats);
            bus.r_resp_i        = (beats == bad_beat) ? 2'b10 : 2'b00;
            bus.r_last_i        = (beats == last_at);
            bus.way_inp_ready_i = toggle ? ((cyc % 2) == 0) : 1'b1;
            @(negedge clk_i);
            if (bus.r_ready_o !== bus.way_inp_ready_i) mirror_bad++;
            if (bus.r_ready_o === 1'b1) beats++;
            @(posedge clk_i); #1;
            cyc++;
        end
        bus.r_valid_i       = 1'b0;
        bus.r_last_i        = 1'b0;
        bus.r_resp_i        = 2'b00;
        bus.way_inp_ready_i = 1'b0;
    endtask

    task automatic finish_send();
        bus.desc_ready_i = 1'b1;
        @(posedge clk_i); #1;
        bus.desc_ready_i = 1'b0;
    endtask

    // ---------------------------------------------------------------- tests
    task automatic test_reset();
        rst_ni = 1'b1;
        #1 rst_ni = 1'b0;
        bus.r_valid_i = 1'b1;
        bus.r_data_i  = 64'hDEAD_BEEF_0000_1111;
        bus.way_inp_ready_i = 1'b1;
        #2;
        checks++;
        if ({bus.desc_ready_o, bus.desc_valid_o, bus.r_ready_o, bus.way_inp_valid_o} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_handshakes: got %b exp 0000",
                     {bus.desc_ready_o, bus.desc_valid_o, bus.r_ready_o, bus.way_inp_valid_o});
        end
        checks++;
        if ({bus.desc_way_ind_o, bus.desc_index_o, bus.desc_id_o, bus.desc_err_o} !== '0) begin
            errors++;
            $display("FAIL reset_desc_out: way %h idx %h id %h err %b exp all 0",
                     bus.desc_way_ind_o, bus.desc_index_o, bus.desc_id_o, bus.desc_err_o);
        end
        checks++;
        if ({bus.way_inp_way_ind_o, bus.way_inp_index_o, bus.way_inp_blk_offset_o, bus.way_inp_data_o} !== '0) begin
            errors++;
            $display("FAIL reset_way_out: way %h idx %h off %0d data %h exp all 0",
                     bus.way_inp_way_ind_o, bus.way_inp_index_o, bus.way_inp_blk_offset_o, bus.way_inp_data_o);
        end
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i); #1;
        @(negedge clk_i);
        checks++;
        if (bus.desc_ready_o !== 1'b1 || bus.r_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: desc_ready %b r_ready %b exp 1 0",
                     bus.desc_ready_o, bus.r_ready_o);
        end
        bus.r_valid_i = 1'b0;
        bus.way_inp_ready_i = 1'b0;
        @(posedge clk_i); #1;
    endtask

    task automatic test_passthrough(input logic [SA-1:0] way, input logic [IL-1:0] idx,
                                    input logic [IW-1:0] id);
        int w0, p0;
        w0 = wr_n; p0 = rr_pulses;
        // An R beat waiting upstream must not be taken by a non-refill descriptor.
        bus.r_valid_i = 1'b1;
        bus.r_data_i  = 64'h5555_AAAA_5555_AAAA;
        bus.way_inp_ready_i = 1'b1;
        bus.desc_valid_i   = 1'b1;
        bus.desc_refill_i  = 1'b0;
        bus.desc_way_ind_i = way;
        bus.desc_index_i   = idx;
        bus.desc_id_i      = id;
        @(negedge clk_i);
        checks++;
        if (bus.desc_ready_o !== 1'b1 || bus.desc_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL pass_accept: desc_ready %b desc_valid %b exp 1 0",
                     bus.desc_ready_o, bus.desc_valid_o);
        end
        @(posedge clk_i); #1;
        bus.desc_valid_i = 1'b0;
        @(negedge clk_i);
        checks++;
        if (bus.desc_valid_o !== 1'b1 || bus.desc_id_o !== id || bus.desc_way_ind_o !== way ||
            bus.desc_index_o !== idx || bus.desc_err_o !== 1'b0 || bus.desc_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL pass_out: valid %b id %h way %h idx %h err %b rdy %b exp 1 %h %h %h 0 0",
                     bus.desc_valid_o, bus.desc_id_o, bus.desc_way_ind_o, bus.desc_index_o,
                     bus.desc_err_o, bus.desc_ready_o, id, way, idx);
        end
        finish_send();
        @(negedge clk_i);
        checks++;
        if (bus.desc_valid_o !== 1'b0 || bus.desc_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL pass_return_idle: valid %b ready %b exp 0 1",
                     bus.desc_valid_o, bus.desc_ready_o);
        end
        checks++;
        if (rr_pulses != p0 || wr_n != w0) begin
            errors++;
            $display("FAIL pass_no_beats: r_ready pulses %0d writes %0d exp 0 0",
                     rr_pulses - p0, wr_n - w0);
        end
        bus.r_valid_i = 1'b0;
        bus.way_inp_ready_i = 1'b0;
        @(posedge clk_i); #1;
    endtask

    // One refill scenario; if stall_cycles > 0 the SEND handshake is delayed.
    task automatic test_refill(input string name, input logic [SA-1:0] way,
                               input logic [IL-1:0] idx, input logic [IW-1:0] id,
                               input logic [DW-1:0] base, input int bad_beat,
                               input int last_at, input bit toggle,
                               input logic exp_err, input int exp_cycles,
                               input int stall_cycles);
        int w0, beats, cyc, mirror_bad;
        w0 = wr_n;
        send_desc(1'b1, way, idx, id);
        drive_beats(base, bad_beat, last_at, toggle, beats, cyc, mirror_bad);
        checks++;
        if (beats != 8 || cyc != exp_cycles) begin
            errors++;
            $display("FAIL %s beats_cycles: beats %0d cycles %0d exp 8 %0d",
                     name, beats, cyc, exp_cycles);
        end
        checks++;
        if (mirror_bad != 0) begin
            errors++;
            $display("FAIL %s r_ready_mirror: %0d mismatching cycles exp 0", name, mirror_bad);
        end
        checks++;
        if (wr_n - w0 != 8) begin
            errors++;
            $display("FAIL %s write_count: got %0d exp 8", name, wr_n - w0);
        end
        for (int i = 0; i < 8; i++) begin
            if (w0 + i < wr_n) begin
                checks++;
                if (wr_off[w0+i] !== BOL'(i) || wr_data[w0+i] !== base + DW'(i) ||
                    wr_way[w0+i] !== way || wr_idx[w0+i] !== idx) begin
                    errors++;
                    $display("FAIL %s write%0d: off %0d data %h way %h idx %h exp %0d %h %h %h",
                             name, i, wr_off[w0+i], wr_data[w0+i], wr_way[w0+i], wr_idx[w0+i],
                             i, base + DW'(i), way, idx);
                end
            end
        end
        for (int s = 0; s <= stall_cycles; s++) begin
            @(negedge clk_i);
            checks++;
            if (bus.desc_valid_o !== 1'b1 || bus.desc_err_o !== exp_err || bus.desc_id_o !== id ||
                bus.desc_way_ind_o !== way || bus.desc_index_o !== idx || bus.desc_ready_o !== 1'b0) begin
                errors++;
                $display("FAIL %s send%0d: valid %b err %b id %h way %h idx %h rdy %b exp 1 %b %h %h %h 0",
                         name, s, bus.desc_valid_o, bus.desc_err_o, bus.desc_id_o,
                         bus.desc_way_ind_o, bus.desc_index_o, bus.desc_ready_o, exp_err, id, way, idx);
            end
            if (s < stall_cycles) begin
                @(posedge clk_i); #1;
            end
        end
        @(posedge clk_i); #1;
        finish_send();
    endtask

    task automatic test_reset_mid_refill();
        int w0;
        w0 = wr_n;
        send_desc(1'b1, 8'h01, 8'h3C, 4'h6);
        for (int b = 0; b < 3; b++) begin
            bus.r_valid_i = 1'b1;
            bus.r_data_i  = 64'h1000 + DW'(b);
            bus.r_resp_i  = 2'b00;
            bus.r_last_i  = 1'b0;
            bus.way_inp_ready_i = 1'b1;
            @(posedge clk_i); #1;
        end
        bus.r_data_i = 64'hFFFF_0000_FFFF_0000;
        rst_ni = 1'b0;
        #2;
        checks++;
        if ({bus.desc_ready_o, bus.desc_valid_o, bus.r_ready_o, bus.way_inp_valid_o} !== 4'b0000) begin
            errors++;
            $display("FAIL midreset_handshakes: got %b exp 0000",
                     {bus.desc_ready_o, bus.desc_valid_o, bus.r_ready_o, bus.way_inp_valid_o});
        end
        checks++;
        if ({bus.way_inp_way_ind_o, bus.way_inp_index_o, bus.way_inp_blk_offset_o, bus.way_inp_data_o,
             bus.desc_way_ind_o, bus.desc_index_o, bus.desc_id_o, bus.desc_err_o} !== '0) begin
            errors++;
            $display("FAIL midreset_data: way %h idx %h off %0d data %h id %h err %b exp all 0",
                     bus.way_inp_way_ind_o, bus.way_inp_index_o, bus.way_inp_blk_offset_o,
                     bus.way_inp_data_o, bus.desc_id_o, bus.desc_err_o);
        end
        @(negedge clk_i);
        rst_ni = 1'b1;
        // R beat still pending upstream: IDLE must not take it nor emit anything.
        for (int c = 0; c < 3; c++) begin
            @(negedge clk_i);
            checks++;
            if (bus.desc_ready_o !== 1'b1 || bus.desc_valid_o !== 1'b0 ||
                bus.r_ready_o !== 1'b0 || bus.way_inp_valid_o !== 1'b0) begin
                errors++;
                $display("FAIL midreset_idle%0d: rdy %b valid %b r_ready %b way_valid %b exp 1 0 0 0",
                         c, bus.desc_ready_o, bus.desc_valid_o, bus.r_ready_o, bus.way_inp_valid_o);
            end
        end
        checks++;
        if (wr_n - w0 != 3) begin
            errors++;
            $display("FAIL midreset_partial_writes: got %0d exp 3", wr_n - w0);
        end
        bus.r_valid_i = 1'b0;
        bus.way_inp_ready_i = 1'b0;
        @(posedge clk_i); #1;
    endtask

    // ---------------------------------------------------------------- main
    initial begin
        bus.desc_valid_i    = 1'b0;
        bus.desc_refill_i   = 1'b0;
        bus.desc_way_ind_i  = '0;
        bus.desc_index_i    = '0;
        bus.desc_id_i       = '0;
        bus.desc_ready_i    = 1'b0;
        bus.r_data_i        = '0;
        bus.r_resp_i        = 2'b00;
        bus.r_last_i        = 1'b0;
        bus.r_valid_i       = 1'b0;
        bus.way_inp_ready_i = 1'b0;

        test_reset();
        test_passthrough(8'h04, 8'h12, 4'h3);
        test_refill("refill_basic",   8'h10, 8'h40, 4'h1, 64'd0,    -1, 7, 1'b0, 1'b0, 8,  0);
        test_refill("refill_backpr",  8'h02, 8'h7F, 4'h2, 64'h100,  -1, 7, 1'b1, 1'b0, 15, 0);
        test_refill("refill_slverr",  8'h20, 8'h01, 4'hA, 64'h200,   4, 7, 1'b0, 1'b1, 8,  0);
        // Error flag from the previous line must not leak into a bypass descriptor.
        test_passthrough(8'h40, 8'hFE, 4'hF);
        test_refill("refill_early_last", 8'h08, 8'h33, 4'h5, 64'h300, -1, 5, 1'b0, 1'b1, 8, 0);
        test_refill("refill_stall",   8'h80, 8'hA5, 4'h9, 64'h400,  -1, 7, 1'b0, 1'b0, 8,  5);
        test_reset_mid_refill();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
